// File: rtl/display_pkg.sv
// ---------------------------------------------------------------------------
// display_pkg
// Shared definitions for the hex display renderer:
//   - glyph geometry (3x5 cells on a 5-pixel horizontal pitch)
//   - 16-entry hex glyph table: 15 bits per glyph, top row in [14:12],
//     bit 2 of each row is the leftmost pixel
//   - renderer FSM state enum
//   - mirror_row(): converts a glyph row into framebuffer bit order, where
//     the leftmost pixel sits at the lowest bit index
// ---------------------------------------------------------------------------
package display_pkg;

   localparam int GLYPH_W     = 3;
   localparam int GLYPH_H     = 5;
   localparam int GLYPH_PITCH = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DRAW = 2'd1,
      DONE = 2'd2
   } render_state_e;

   localparam logic [14:0] HEX_GLYPHS [16] = '{
      15'b111_101_101_101_111,   // 0
      15'b001_001_001_001_001,   // 1
      15'b111_001_111_100_111,   // 2
      15'b111_001_111_001_111,   // 3
      15'b101_101_111_001_001,   // 4
      15'b111_100_111_001_111,   // 5
      15'b111_100_111_101_111,   // 6
      15'b111_001_001_001_001,   // 7
      15'b111_101_111_101_111,   // 8
      15'b111_101_111_001_111,   // 9
      15'b111_101_111_101_101,   // A
      15'b110_101_110_101_110,   // B
      15'b111_100_100_100_111,   // C
      15'b110_101_101_101_110,   // D
      15'b111_100_111_100_111,   // E
      15'b111_100_111_100_100    // F
   };

   // Glyph rows keep the left pixel in bit 2; the framebuffer grows with x,
   // so the row is reversed before it is dropped into the pixel vector.
   function automatic logic [2:0] mirror_row(input logic [2:0] row_bits);
      return {row_bits[0], row_bits[1], row_bits[2]};
   endfunction

endpackage

// File: rtl/hex_glyph_rom.sv
// ---------------------------------------------------------------------------
// hex_glyph_rom
// Combinational lookup of one 3-pixel row of a hex glyph.
// Ports:
//   nibble   in  4  hex digit to look up
//   row      in  3  glyph row, 0 = top; rows beyond 4 read as blank
//   row_bits out 3  pixel row, bit 2 = leftmost pixel
// ---------------------------------------------------------------------------
module hex_glyph_rom
   import display_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic [2:0] row,
   output logic [2:0] row_bits
);

   logic [14:0] glyph;

   always_comb begin
      glyph = HEX_GLYPHS[nibble];
      case (row)
         3'd0:    row_bits = glyph[14:12];
         3'd1:    row_bits = glyph[11:9];
         3'd2:    row_bits = glyph[8:6];
         3'd3:    row_bits = glyph[5:3];
         3'd4:    row_bits = glyph[2:0];
         default: row_bits = 3'b000;
      endcase
   end

endmodule

// File: rtl/hex_display_renderer.sv
// ---------------------------------------------------------------------------
// hex_display_renderer
// Draws a DIGITS-wide hex value as 3x5 glyphs into a registered 1-bit
// framebuffer, one glyph row per clock, with optional leading-zero blanking.
// Ports:
//   clock         in   1           system clock, rising edge
//   reset_n       in   1           asynchronous active-low reset
//   value         in   4*DIGITS    value to render, MS nibble is digit 0
//   load          in   1           render request (accepted in IDLE/DONE)
//   blank_leading in   1           suppress leading zeros, captured with load
//   busy          out  1           high while rows are being written
//   done          out  1           one-cycle pulse after the last row
//   framebuffer   out  FB_W*FB_H   pixel (x,y) at bit y*FB_W+x
// ---------------------------------------------------------------------------
module hex_display_renderer
   import display_pkg::*;
#(
   parameter int FB_W   = 40,
   parameter int FB_H   = 30,
   parameter int DIGITS = 2,
   parameter int X0     = 16,
   parameter int Y0     = 1
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic [4*DIGITS-1:0]    value,
   input  logic                   load,
   input  logic                   blank_leading,
   output logic                   busy,
   output logic                   done,
   output logic [FB_W*FB_H-1:0]   framebuffer
);

   localparam int FB_N  = FB_W * FB_H;
   localparam int IDX_W = (FB_N > 1) ? $clog2(FB_N) : 1;
   localparam int D_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [D_W-1:0] LAST_D   = D_W'(DIGITS - 1);
   localparam logic [2:0]     LAST_ROW = 3'(GLYPH_H - 1);

   generate
      if (DIGITS < 1) begin : g_bad_digits
         $error("hex_display_renderer: DIGITS must be at least 1");
      end
      if (X0 + GLYPH_PITCH * (DIGITS - 1) + GLYPH_W > FB_W) begin : g_bad_width
         $error("hex_display_renderer: digit cells exceed FB_W");
      end
      if (Y0 + GLYPH_H > FB_H) begin : g_bad_height
         $error("hex_display_renderer: glyph rows exceed FB_H");
      end
   endgenerate

   render_state_e        state_reg, state_next;
   logic [4*DIGITS-1:0]  value_reg, value_next;
   logic                 blank_reg, blank_next;
   logic                 seen_reg, seen_next;     // a nonzero nibble has been drawn
   logic [D_W-1:0]       d_reg, d_next;
   logic [2:0]           r_reg, r_next;
   logic [FB_N-1:0]      fb_reg, fb_next;

   logic [3:0]           nibbles [DIGITS];
   logic [3:0]           cur_nibble;
   logic [2:0]           rom_row;
   logic [2:0]           draw_row;
   logic                 blank_digit;
   logic [IDX_W-1:0]     pix_base;

   // Digit 0 is the most significant nibble.
   generate
      for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nibble
         assign nibbles[gi] = value_reg[4*(DIGITS-1-gi) +: 4];
      end
   endgenerate

   assign cur_nibble = nibbles[d_reg];

   hex_glyph_rom u_rom (
      .nibble   (cur_nibble),
      .row      (r_reg),
      .row_bits (rom_row)
   );

   // A digit is blanked only while every more-significant nibble was zero;
   // the last digit is always drawn so a zero value still shows "0".
   assign blank_digit = blank_reg && !seen_reg && (cur_nibble == 4'd0) && (d_reg != LAST_D);
   assign draw_row    = blank_digit ? 3'b000 : rom_row;

   assign pix_base = IDX_W'((Y0 + int'(r_reg)) * FB_W + X0 + GLYPH_PITCH * int'(d_reg));

   always_comb begin
      state_next = state_reg;
      value_next = value_reg;
      blank_next = blank_reg;
      seen_next  = seen_reg;
      d_next     = d_reg;
      r_next     = r_reg;
      fb_next    = fb_reg;
      busy       = 1'b0;
      done       = 1'b0;

      case (state_reg)
         IDLE, DONE: begin
            done = (state_reg == DONE);
            if (load) begin
               value_next = value;
               blank_next = blank_leading;
               seen_next  = 1'b0;
               d_next     = '0;
               r_next     = 3'd0;
               state_next = DRAW;
            end else begin
               state_next = IDLE;
            end
         end

         DRAW: begin
            busy = 1'b1;
            // All three pixels are written so a previous glyph never survives.
            fb_next[pix_base +: GLYPH_W] = mirror_row(draw_row);
            if (cur_nibble != 4'd0) begin
               seen_next = 1'b1;
            end
            if (r_reg == LAST_ROW) begin
               r_next = 3'd0;
               if (d_reg == LAST_D) begin
                  d_next     = '0;
                  state_next = DONE;
               end else begin
                  d_next = d_reg + D_W'(1);
               end
            end else begin
               r_next = r_reg + 3'd1;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= IDLE;
         value_reg <= '0;
         blank_reg <= 1'b0;
         seen_reg  <= 1'b0;
         d_reg     <= '0;
         r_reg     <= 3'd0;
         fb_reg    <= '0;
      end else begin
         state_reg <= state_next;
         value_reg <= value_next;
         blank_reg <= blank_next;
         seen_reg  <= seen_next;
         d_reg     <= d_next;
         r_reg     <= r_next;
         fb_reg    <= fb_next;
      end
   end

   assign framebuffer = fb_reg;

endmodule

// File: tb/tb_hex_display_renderer.sv
module tb_hex_display_renderer;

   localparam int FB_W   = 40;
   localparam int FB_H   = 30;
   localparam int DIGITS = 2;
   localparam int X0     = 16;
   localparam int Y0     = 1;
   localparam int FB_N   = FB_W * FB_H;
   localparam int VW     = 4 * DIGITS;
   localparam int LAT    = 5 * DIGITS;

   logic              clock = 1'b0;
   logic              reset_n = 1'b0;
   logic [VW-1:0]     value = '0;
   logic              load = 1'b0;
   logic              blank_leading = 1'b0;
   logic              busy;
   logic              done;
   logic [FB_N-1:0]   framebuffer;

   int n_cmp = 0;
   int n_bad = 0;

   logic [FB_N-1:0] cell_mask;

   // Pixel-art font: rows separated by '/', '#' is a lit pixel, left to right.
   string font [16] = '{
      "###/#.#/#.#/#.#/###", "..#/..#/..#/..#/..#",
      "###/..#/###/#../###", "###/..#/###/..#/###",
      "#.#/#.#/###/..#/..#", "###/#../###/..#/###",
      "###/#../###/#.#/###", "###/..#/..#/..#/..#",
      "###/#.#/###/#.#/###", "###/#.#/###/..#/###",
      "###/#.#/###/#.#/#.#", "##./#.#/##./#.#/##.",
      "###/#../#../#../###", "##./#.#/#.#/#.#/##.",
      "###/#../###/#../###", "###/#../###/#../#.."
   };

   hex_display_renderer #(
      .FB_W(FB_W), .FB_H(FB_H), .DIGITS(DIGITS), .X0(X0), .Y0(Y0)
   ) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .value         (value),
      .load          (load),
      .blank_leading (blank_leading),
      .busy          (busy),
      .done          (done),
      .framebuffer   (framebuffer)
   );

   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Expected picture after rendering v from a blank screen or any earlier
   // render: cells are fully overwritten, nothing else is ever lit.
   function automatic logic [FB_N-1:0] model_fb(input logic [VW-1:0] v, input logic bl);
      logic [FB_N-1:0] fb;
      fb = '0;
      for (int d = 0; d < DIGITS; d++) begin
         int  sh;
         int  nib;
         bit  hide;
         sh   = 4 * (DIGITS - 1 - d);
         nib  = int'((v >> sh) & VW'(15));
         hide = bl && ((v >> sh) == '0) && (d != DIGITS - 1);
         for (int r = 0; r < 5; r++)
            for (int c = 0; c < 3; c++)
               if (!hide && font[nib].getc(r * 4 + c) == 8'h23)
                  fb[(Y0 + r) * FB_W + X0 + 5 * d + c] = 1'b1;
      end
      return fb;
   endfunction

   function automatic int first_diff(input logic [FB_N-1:0] a, input logic [FB_N-1:0] b);
      for (int i = 0; i < FB_N; i++)
         if (a[i] !== b[i]) return i;
      return -1;
   endfunction

   // Drives one load pulse and observes the render to completion.
   task automatic run_render(input logic [VW-1:0] v, input logic bl,
                             output int lat, output bit proto_ok,
                             output logic [FB_N-1:0] fb_done, output logic done_next);
      lat      = -1;
      proto_ok = 1'b1;
      @(negedge clock);
      value = v; blank_leading = bl; load = 1'b1;
      @(posedge clock);
      @(negedge clock);
      load = 1'b0;
      if (busy !== 1'b1 || done !== 1'b0) proto_ok = 1'b0;
      for (int i = 1; i <= 4 * LAT; i++) begin
         @(negedge clock);
         if (busy === 1'b1 && done === 1'b1) proto_ok = 1'b0;
         if (done !== 1'b1 && busy !== 1'b1) proto_ok = 1'b0;
         if ((framebuffer & ~cell_mask) !== '0) proto_ok = 1'b0;
         if (done === 1'b1) begin
            lat = i;
            break;
         end
      end
      fb_done = framebuffer;
      @(negedge clock);
      done_next = done;
      $display("render value=%h blank=%0d latency=%0d", v, bl, lat);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (2) @(negedge clock);
      n_cmp++; if (framebuffer !== '0) begin n_bad++; $display("FAIL reset_fb: actual nonzero at bit %0d, required 0", first_diff(framebuffer, '0)); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: actual %b required 0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: actual %b required 0", done); end
      reset_n = 1'b1;
      $display("reset applied and released");
   endtask

   task automatic test_hex_1a();
      int lat; bit ok; logic [FB_N-1:0] fb; logic dn;
      int ones [8] = '{58, 98, 138, 178, 218, 61, 62, 63};
      run_render(8'h1A, 1'b0, lat, ok, fb, dn);
      n_cmp++; if (lat !== LAT) begin n_bad++; $display("FAIL 1a_latency: actual %0d required %0d", lat, LAT); end
      n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL 1a_protocol: actual %b required 1", ok); end
      n_cmp++; if (dn !== 1'b0) begin n_bad++; $display("FAIL 1a_done_width: actual %b required 0", dn); end
      n_cmp++; if (fb !== model_fb(8'h1A, 1'b0)) begin n_bad++; $display("FAIL 1a_fb: first diff bit %0d actual %b required %b", first_diff(fb, model_fb(8'h1A, 1'b0)), fb[first_diff(fb, model_fb(8'h1A, 1'b0))], ~fb[first_diff(fb, model_fb(8'h1A, 1'b0))]); end
      foreach (ones[i]) begin
         n_cmp++; if (fb[ones[i]] !== 1'b1) begin n_bad++; $display("FAIL 1a_bit%0d: actual %b required 1", ones[i], fb[ones[i]]); end
      end
      n_cmp++; if (fb[57:56] !== 2'b00) begin n_bad++; $display("FAIL 1a_bits56_57: actual %b required 00", fb[57:56]); end
   endtask

   task automatic test_blank_07();
      int lat; bit ok; logic [FB_N-1:0] fb; logic dn;
      run_render(8'h07, 1'b1, lat, ok, fb, dn);
      n_cmp++; if (fb !== model_fb(8'h07, 1'b1)) begin n_bad++; $display("FAIL b07_fb: first diff bit %0d", first_diff(fb, model_fb(8'h07, 1'b1))); end
      for (int y = 1; y <= 5; y++)
         for (int x = 16; x <= 18; x++) begin
            n_cmp++; if (fb[y * FB_W + x] !== 1'b0) begin n_bad++; $display("FAIL b07_cell0 x=%0d y=%0d: actual %b required 0", x, y, fb[y * FB_W + x]); end
         end
      n_cmp++; if (fb[63:61] !== 3'b111) begin n_bad++; $display("FAIL b07_top7: actual %b required 111", fb[63:61]); end
      n_cmp++; if (lat !== LAT || ok !== 1'b1) begin n_bad++; $display("FAIL b07_protocol: latency %0d ok %b required %0d 1", lat, ok, LAT); end
   endtask

   task automatic test_blank_00();
      int lat; bit ok; logic [FB_N-1:0] fb; logic dn;
      run_render(8'h00, 1'b1, lat, ok, fb, dn);
      n_cmp++; if (fb !== model_fb(8'h00, 1'b1)) begin n_bad++; $display("FAIL b00_fb: first diff bit %0d", first_diff(fb, model_fb(8'h00, 1'b1))); end
      n_cmp++; if (fb[58:56] !== 3'b000) begin n_bad++; $display("FAIL b00_cell0_top: actual %b required 000", fb[58:56]); end
      n_cmp++; if (fb[103:101] !== 3'b101) begin n_bad++; $display("FAIL b00_zero_mid: actual %b required 101", fb[103:101]); end
   endtask

   task automatic test_overwrite();
      int lat; bit ok; logic [FB_N-1:0] fb; logic dn;
      run_render(8'h88, 1'b0, lat, ok, fb, dn);
      n_cmp++; if (fb !== model_fb(8'h88, 1'b0)) begin n_bad++; $display("FAIL ow88_fb: first diff bit %0d", first_diff(fb, model_fb(8'h88, 1'b0))); end
      run_render(8'h11, 1'b0, lat, ok, fb, dn);
      n_cmp++; if (fb !== model_fb(8'h11, 1'b0)) begin n_bad++; $display("FAIL ow11_fb: first diff bit %0d", first_diff(fb, model_fb(8'h11, 1'b0))); end
      n_cmp++; if (fb[57:56] !== 2'b00) begin n_bad++; $display("FAIL ow11_bits56_57: actual %b required 00", fb[57:56]); end
      n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL ow_outside_or_protocol: actual %b required 1", ok); end
   endtask

   task automatic test_random();
      int lat; bit ok; logic [FB_N-1:0] fb; logic dn;
      logic [VW-1:0] v; logic bl;
      for (int t = 0; t < 12; t++) begin
         v  = VW'($urandom);
         bl = 1'($urandom);
         if ($urandom_range(0, 2) == 0) v[VW-1 -: 4] = 4'h0;
         if ($urandom_range(0, 5) == 0) v = '0;
         run_render(v, bl, lat, ok, fb, dn);
         n_cmp++; if (fb !== model_fb(v, bl)) begin n_bad++; $display("FAIL rand_fb value=%h blank=%0d: first diff bit %0d", v, bl, first_diff(fb, model_fb(v, bl))); end
         n_cmp++; if (lat !== LAT || ok !== 1'b1 || dn !== 1'b0) begin n_bad++; $display("FAIL rand_protocol value=%h: latency %0d ok %b done_next %b required %0d 1 0", v, lat, ok, dn, LAT); end
      end
   endtask

   task automatic test_back_to_back();
      logic [VW-1:0] c; logic bc; int lat;
      c  = VW'($urandom);
      bc = 1'($urandom);
      @(negedge clock);
      value = 8'h05; blank_leading = 1'b0; load = 1'b1;
      @(posedge clock);
      // load stays high; value/blank scramble while drawing
      for (int i = 0; i < LAT; i++) begin
         @(negedge clock);
         n_cmp++; if (busy !== 1'b1 || done !== 1'b0) begin n_bad++; $display("FAIL b2b_draw cycle %0d: busy %b done %b required 1 0", i, busy, done); end
         value = VW'($urandom); blank_leading = 1'b1;
      end
      @(negedge clock);
      n_cmp++; if (done !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL b2b_first_done: busy %b done %b required 0 1", busy, done); end
      n_cmp++; if (framebuffer !== model_fb(8'h05, 1'b0)) begin n_bad++; $display("FAIL b2b_first_fb: first diff bit %0d", first_diff(framebuffer, model_fb(8'h05, 1'b0))); end
      value = c; blank_leading = bc;
      @(posedge clock);
      @(negedge clock);
      load = 1'b0;
      n_cmp++; if (busy !== 1'b1 || done !== 1'b0) begin n_bad++; $display("FAIL b2b_restart: busy %b done %b required 1 0", busy, done); end
      lat = -1;
      for (int i = 1; i <= 4 * LAT; i++) begin
         @(negedge clock);
         if (done === 1'b1) begin lat = i; break; end
      end
      n_cmp++; if (lat !== LAT) begin n_bad++; $display("FAIL b2b_second_latency: actual %0d required %0d", lat, LAT); end
      n_cmp++; if (framebuffer !== model_fb(c, bc)) begin n_bad++; $display("FAIL b2b_second_fb value=%h: first diff bit %0d", c, first_diff(framebuffer, model_fb(c, bc))); end
      @(negedge clock);
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL b2b_done_width: actual %b required 0", done); end
      $display("back-to-back renders 05 then %h blank=%0d second latency=%0d", c, bc, lat);
   endtask

   task automatic test_reset_mid();
      int lat; bit ok; logic [FB_N-1:0] fb; logic dn; logic [VW-1:0] v;
      @(negedge clock);
      value = 8'hFF; blank_leading = 1'b0; load = 1'b1;
      @(posedge clock);
      @(negedge clock);
      load = 1'b0;
      repeat (4) @(posedge clock);
      #2 reset_n = 1'b0;
      #1;
      n_cmp++; if (framebuffer !== '0) begin n_bad++; $display("FAIL midreset_fb: nonzero at bit %0d, required 0", first_diff(framebuffer, '0)); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midreset_busy: actual %b required 0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL midreset_done: actual %b required 0", done); end
      $display("reset asserted mid-draw");
      @(negedge clock);
      reset_n = 1'b1;
      v = VW'($urandom);
      run_render(v, 1'b1, lat, ok, fb, dn);
      n_cmp++; if (fb !== model_fb(v, 1'b1)) begin n_bad++; $display("FAIL postreset_fb value=%h: first diff bit %0d", v, first_diff(fb, model_fb(v, 1'b1))); end
      n_cmp++; if (lat !== LAT || ok !== 1'b1) begin n_bad++; $display("FAIL postreset_protocol: latency %0d ok %b required %0d 1", lat, ok, LAT); end
   endtask

   initial begin
      cell_mask = '0;
      for (int d = 0; d < DIGITS; d++)
         for (int r = 0; r < 5; r++)
            for (int c = 0; c < 3; c++)
               cell_mask[(Y0 + r) * FB_W + X0 + 5 * d + c] = 1'b1;

      test_reset();
      test_hex_1a();
      test_blank_07();
      test_blank_00();
      test_overwrite();
      test_random();
      test_back_to_back();
      test_reset_mid();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/hex_display_renderer.md
# hex_display_renderer

Sequential renderer that draws a DIGITS-wide hexadecimal value as 3x5-pixel glyphs into a registered, parametrised 1-bit framebuffer. It sits between game/value logic and the VGA scanner, replacing per-digit combinational wiring. Rendering is one glyph row per clock under a load/busy/done handshake, with optional leading-zero blanking.

## Interface
- FB_W, 40: framebuffer width in pixels
- FB_H, 30: framebuffer height in pixels
- DIGITS, 2: number of hex digits rendered
- X0, 16: x of the leftmost pixel of digit 0, which is the most significant nibble
- Y0, 1: y of the top glyph row
- clock  in  1  single system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- value  in  4*DIGITS  value to render; nibble [4*DIGITS-1:4*DIGITS-4] is digit 0
- load  in  1  render request; sampled only in IDLE or DONE
- blank_leading  in  1  mode bit, captured with load; 1 suppresses leading zeros
- busy  out  1  high while rendering
- done  out  1  one-cycle pulse after the last row write
- framebuffer  out  FB_W*FB_H  registered pixels; pixel (x,y) is bit y*FB_W+x, with x=0 leftmost

## Operation
- FSM states IDLE, DRAW, DONE; reset state IDLE.
- IDLE/DONE with load=1: capture value and blank_leading; clear digit index d and row index r; go to DRAW.
- DRAW: each cycle writes glyph row r of digit d to pixels x = X0+5d .. X0+5d+2 at y = Y0+r.
  - Glyph row bit 2 maps to the leftmost pixel.
  - All 3 bits are written, zeros included, so the previous glyph is fully overwritten.
  - r increments 0..4. On wrap, r resets to 0 and d increments.
  - After the write with d=DIGITS-1 and r=4, the FSM goes to DONE.
- DONE: done=1 for one cycle. With load=0 return to IDLE; with load=1 restart DRAW (back-to-back accepted).
- Leading-zero blanking, when enabled:
  - Digit d is written as 000 on all rows if its nibble and every more-significant nibble are zero.
  - The last digit is always drawn, so 0 renders as "0".
- Pixels outside the digit cells are never written and keep their reset value of 0.
- load in DRAW is ignored and not queued.
- value and blank_leading changes after capture have no effect on the render in progress.

## Timing
- Reset (async, any state, including mid-DRAW): framebuffer=0, busy=0, done=0, state IDLE, d=r=0. Effective immediately.
- Edge E0 samples load. After E0, busy=1.
- Edges E1..E(5*DIGITS) each write one row; each write is visible after its edge.
- After E(5*DIGITS): busy=0, done=1 for exactly one cycle.
- Total latency from the load edge to the done pulse is 5*DIGITS cycles. With the defaults this is 10.
- busy and done are never high together.
- Elaboration errors:
  - X0+5*(DIGITS-1)+3 > FB_W
  - Y0+5 > FB_H
  - DIGITS < 1

## Structure
- Shared package display_pkg holds:
  - constants GLYPH_W=3, GLYPH_H=5, GLYPH_PITCH=5
  - the 16-entry hex glyph table: 15 bits each, top row in bits [14:12], bit 2 of each row = left pixel
  - the FSM state enum
- One combinational sub-module, hex_glyph_rom: nibble and row index in, 3-bit row out.
- The renderer owns the FSM, the d/r counters, the blanking flag (sticky "nonzero seen") and the framebuffer register.

## Test plan
- Defaults, value=0x1A, blank_leading=0, load pulse:
  - after done, bits 58,98,138,178,218 = 1 and bits 56,57 = 0 ("1")
  - bits 61,62,63 = 1 (top of "A")
  - done exactly 10 cycles after the load edge
- value=0x07, blank_leading=1:
  - digit-0 cell (x 16..18, y 1..5) all 0
  - digit-1 top row bits 61..63 = 1
- value=0x00, blank_leading=1:
  - digit 0 blank
  - digit 1 draws "0": bits 101,103 = 1, bit 102 = 0
- Render 0x88, then 0x11:
  - no stale pixels remain
  - bits 56,57 = 0 afterwards
  - no pixel outside the cells is ever set
- load held during DRAW: ignored; single done pulse; load asserted in the DONE cycle starts a second render immediately.
- reset_n low at cycle 4 of DRAW: framebuffer, busy and done all 0 asynchronously; a subsequent load renders correctly.
